// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the mips32 multicycle main control: opcodes, FSM states,
// datapath select codes and the control vector driven by the output decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_RTEXEC = 4'd6,
    ST_RTWB   = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_IEXEC  = 4'd10,
    ST_IWB    = 4'd11
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] ext_op;
    logic       illegal_op;
    logic       retire;
  } ctrl_t;

  // Logical immediates are zero-extended; lui places the immediate in the upper half.
  function automatic logic [1:0] imm_ext_mode(input logic [5:0] op);
    case (op)
      OP_ANDI, OP_ORI: return EXT_ZERO;
      OP_LUI:          return EXT_LUI;
      default:         return EXT_SIGN;
    endcase
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_J: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outputs.sv
// Combinational control-vector decode from state, opcode and mem_ready; kept
// separate so a pipelined decoder can reuse the same per-state map.
module mips_ctrl_outputs
  import mips_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl           = '0;
    ctrl.pc_source = PCSRC_ALU;
    ctrl.alu_op    = ALU_ADD;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // IR and PC load only in the handshake cycle.
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
        end else begin
          ctrl.ir_write = 1'b0;
          ctrl.pc_write = 1'b0;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.ext_op     = EXT_SIGN;
        ctrl.illegal_op = ~op_supported(opcode);
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = EXT_SIGN;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = mem_ready;
      end
      ST_RTEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
        ctrl.retire        = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
      end
      ST_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_IMM;
        ctrl.ext_op    = imm_ext_mode(opcode);
      end
      ST_IWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
        ctrl.ext_op    = imm_ext_mode(opcode);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle main control FSM for mips32: state register, memory-wait timeout
// counter and next-state logic; the control vector comes from mips_ctrl_outputs.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] ext_op,
  output logic       illegal_op,
  output logic       mem_fault,
  output logic       retire,
  output logic [3:0] state
);

  state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                   in_wait_s;
  logic                   timeout_s;
  ctrl_t                  ctrl_s;
  ctrl_t                  ctrl_out_s;
  logic                   unused_funct;

  // funct is decoded by the ALU control, not here.
  assign unused_funct = ^funct;

  assign in_wait_s = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
  // Fires in the wait cycle after 2^TIMEOUT_W-1 unanswered cycles.
  assign timeout_s = in_wait_s && !mem_ready && (wait_cnt_q == {TIMEOUT_W{1'b1}});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    if (in_wait_s && !mem_ready && !timeout_s) begin
      wait_cnt_d = wait_cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_d = '0;
    end
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else           state_d = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                     state_d = ST_MEMADR;
          OP_RTYPE:                         state_d = ST_RTEXEC;
          OP_BEQ, OP_BNE:                   state_d = ST_BRANCH;
          OP_J:                             state_d = ST_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = ST_IEXEC;
          default:                          state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_SW) state_d = ST_MEMWR;
        else                 state_d = ST_MEMRD;
      end
      ST_MEMRD: begin
        if (mem_ready)      state_d = ST_MEMWB;
        else if (timeout_s) state_d = ST_FETCH;
        else                state_d = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready || timeout_s) state_d = ST_FETCH;
        else                        state_d = ST_MEMWR;
      end
      ST_RTEXEC: state_d = ST_RTWB;
      ST_IEXEC:  state_d = ST_IWB;
      ST_MEMWB, ST_RTWB, ST_BRANCH, ST_JUMP, ST_IWB: state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  mips_ctrl_outputs u_outputs (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_s)
  );

  // Reset silences every strobe immediately, independent of the clock.
  always_comb begin
    if (reset) ctrl_out_s = '0;
    else       ctrl_out_s = ctrl_s;
  end

  assign pc_write      = ctrl_out_s.pc_write;
  assign pc_write_cond = ctrl_out_s.pc_write_cond;
  assign branch_ne     = ctrl_out_s.branch_ne;
  assign pc_source     = ctrl_out_s.pc_source;
  assign i_or_d        = ctrl_out_s.i_or_d;
  assign mem_read      = ctrl_out_s.mem_read;
  assign mem_write     = ctrl_out_s.mem_write;
  assign ir_write      = ctrl_out_s.ir_write;
  assign reg_dst       = ctrl_out_s.reg_dst;
  assign mem_to_reg    = ctrl_out_s.mem_to_reg;
  assign reg_write     = ctrl_out_s.reg_write;
  assign alu_src_a     = ctrl_out_s.alu_src_a;
  assign alu_src_b     = ctrl_out_s.alu_src_b;
  assign alu_op        = ctrl_out_s.alu_op;
  assign ext_op        = ctrl_out_s.ext_op;
  assign illegal_op    = ctrl_out_s.illegal_op;
  assign retire        = ctrl_out_s.retire;
  assign mem_fault     = timeout_s & ~reset;
  assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: per-instruction route model compared every cycle,
// directed instruction scenarios with literal expectations, then random traffic.
module tb_mips_multicycle_control;

  localparam int TW   = 3;
  localparam int TMAX = (1 << TW) - 1;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic       illegal_op, mem_fault, retire;
  logic [1:0] pc_source, alu_src_b, alu_op, ext_op;
  logic [3:0] state;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, ext_op;
    logic       illegal_op, mem_fault, retire;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                  ext_op, illegal_op, mem_fault, retire};

  mips_multicycle_control #(.TIMEOUT_W(TW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
    .illegal_op(illegal_op), .mem_fault(mem_fault), .retire(retire), .state(state)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         m_state, m_wait, m_pos;
  logic [5:0] m_op;
  outs_t      last_o;
  logic [3:0] last_st;
  outs_t      tr_o[64];
  logic [3:0] tr_s[64];

  // States visited after DECODE for each instruction; 0 marks the return to FETCH.
  function automatic int route_at(input logic [5:0] op, input int k);
    int r[3];
    r = '{0, 0, 0};
    case (op)
      6'b100011:                               r = '{2, 3, 4};
      6'b101011:                               r = '{2, 5, 0};
      6'b000000:                               r = '{6, 7, 0};
      6'b000100, 6'b000101:                    r = '{8, 0, 0};
      6'b000010:                               r = '{9, 0, 0};
      6'b001000, 6'b001100, 6'b001101, 6'b001111: r = '{10, 11, 0};
      default:                                 r = '{0, 0, 0};
    endcase
    return (k < 3) ? r[k] : 0;
  endfunction

  function automatic logic [1:0] ext_of(input logic [5:0] op);
    if (op == 6'b001100 || op == 6'b001101) return 2'b01;
    else if (op == 6'b001111)               return 2'b10;
    else                                    return 2'b00;
  endfunction

  function automatic outs_t expect_outs(input int st, input logic [5:0] op, input logic rdy,
                                        input int wt);
    outs_t o;
    logic  starving;
    o = '0;
    starving = !rdy && (wt == TMAX);
    case (st)
      0: begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy;
               o.mem_fault = starving; end
      1: begin o.alu_src_b = 2'b11; o.illegal_op = (route_at(op, 0) == 0); end
      2: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      3: begin o.mem_read = 1'b1; o.i_or_d = 1'b1; o.mem_fault = starving; end
      4: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.retire = 1'b1; end
      5: begin o.mem_write = 1'b1; o.i_or_d = 1'b1; o.retire = rdy; o.mem_fault = starving; end
      6: begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      7: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; o.retire = 1'b1; end
      8: begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
               o.pc_source = 2'b01; o.branch_ne = (op == 6'b000101); o.retire = 1'b1; end
      9: begin o.pc_write = 1'b1; o.pc_source = 2'b10; o.retire = 1'b1; end
      10: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; o.ext_op = ext_of(op); end
      11: begin o.reg_write = 1'b1; o.retire = 1'b1; o.ext_op = ext_of(op); end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_pos = 0;
  endtask

  task automatic model_step();
    logic waiting;
    waiting = (m_state == 0) || (m_state == 3) || (m_state == 5);
    if (waiting && !mem_ready) begin
      if (m_wait == TMAX) model_reset();
      else m_wait++;
    end else begin
      m_wait = 0;
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin m_op = opcode; m_state = route_at(opcode, 0); m_pos = 1; end
      else begin m_state = route_at(m_op, m_pos); m_pos++; end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clock);
    last_o  = dut_o;
    last_st = state;
    if (reset) begin
      check("reset_outs", 32'(dut_o), 32'd0);
      check("reset_state", 32'(state), 32'd0);
    end else begin
      check("cycle_outs", 32'(dut_o), 32'(expect_outs(m_state, opcode, mem_ready, m_wait)));
      check("cycle_state", 32'(state), 32'(m_state));
    end
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  // Runs one instruction from FETCH: fw stalled fetch cycles, mw stalled memory cycles.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, output int n);
    int f, w;
    logic left;
    f = fw; w = mw; n = 0; left = 1'b0;
    opcode = op;
    while (n < 40) begin
      if (m_state == 0) begin mem_ready = (f == 0); if (f > 0) f--; end
      else if (m_state == 3 || m_state == 5) begin mem_ready = (w == 0); if (w > 0) w--; end
      else mem_ready = 1'($urandom_range(0, 1));
      tick();
      tr_o[n] = last_o; tr_s[n] = last_st; n++;
      if (m_state != 0) left = 1'b1;
      else if (left) break;
    end
    check("instr_completes", 32'(left && m_state == 0), 32'd1);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[10];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b001000, 6'b001100, 6'b001101, 6'b001111, 6'b000010};
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    else return ops[$urandom_range(0, 9)];
  endfunction

  initial begin
    int n, s_ir, s_ret, s_flt, s_wr;
    int lw_seq[4];
    int pct;
    lw_seq = '{1, 2, 3, 4};
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b0;
    model_reset(); m_op = 6'd0;
    tick();
    reset = 1'b0;

    // lw with three stalled fetch cycles
    run_instr(6'b100011, 3, 0, n);
    check("lw_cycles", 32'(n), 32'd8);
    s_ir = 0; s_ret = 0;
    for (int i = 0; i < n; i++) begin s_ir += int'(tr_o[i].ir_write); s_ret += int'(tr_o[i].retire); end
    check("lw_ir_write_once", 32'(s_ir), 32'd1);
    check("lw_ready_cycle_loads", 32'({tr_o[3].ir_write, tr_o[3].pc_write}), 32'd3);
    check("lw_stall_no_pc_write", 32'(tr_o[2].pc_write), 32'd0);
    for (int i = 0; i < 4; i++) check("lw_state_seq", 32'(tr_s[4+i]), 32'(lw_seq[i]));
    check("lw_memwb_write", 32'({tr_o[7].reg_write, tr_o[7].mem_to_reg, tr_o[7].reg_dst}), 32'd6);
    check("lw_retire_once", 32'(s_ret), 32'd1);

    // andi then lui: extender mode through IEXEC and IWB
    run_instr(6'b001100, 0, 0, n);
    check("andi_cycles", 32'(n), 32'd4);
    check("andi_iexec_state", 32'(tr_s[2]), 32'd10);
    check("andi_ext", 32'({tr_o[2].ext_op, tr_o[3].ext_op}), 32'h5);
    check("andi_iwb", 32'({tr_o[3].reg_write, tr_o[3].reg_dst}), 32'd2);
    run_instr(6'b001111, 0, 0, n);
    check("lui_cycles", 32'(n), 32'd4);
    check("lui_ext", 32'({tr_o[2].ext_op, tr_o[3].ext_op}), 32'hA);
    check("lui_reg_dst", 32'(tr_o[3].reg_dst), 32'd0);

    // bne / beq
    run_instr(6'b000101, 0, 0, n);
    check("bne_state", 32'(tr_s[2]), 32'd8);
    check("bne_ctrl", 32'({tr_o[2].pc_write_cond, tr_o[2].branch_ne, tr_o[2].pc_source}), 32'hD);
    run_instr(6'b000100, 0, 0, n);
    check("beq_ctrl", 32'({tr_o[2].pc_write_cond, tr_o[2].branch_ne, tr_o[2].pc_source}), 32'h9);

    // unsupported opcode
    run_instr(6'b111111, 0, 0, n);
    check("illegal_cycles", 32'(n), 32'd2);
    check("illegal_pulse", 32'({tr_o[0].illegal_op, tr_o[1].illegal_op}), 32'd1);
    s_wr = 0;
    for (int i = 0; i < n; i++) s_wr += int'(tr_o[i].reg_write) + int'(tr_o[i].mem_write);
    check("illegal_no_writes", 32'(s_wr), 32'd0);

    // sw with memory never ready: fault on the 8th MEMWR cycle
    run_instr(6'b101011, 0, 100, n);
    check("sw_timeout_cycles", 32'(n), 32'd11);
    s_ret = 0; s_flt = 0;
    for (int i = 0; i < n; i++) begin s_ret += int'(tr_o[i].retire); s_flt += int'(tr_o[i].mem_fault); end
    check("sw_fault_once", 32'(s_flt), 32'd1);
    check("sw_fault_cycle", 32'({tr_s[10], tr_o[10].mem_fault}), 32'hB);
    check("sw_no_retire", 32'(s_ret), 32'd0);
    check("sw_back_to_fetch", 32'(state), 32'd0);

    // reset asserted in MEMRD while memory stalls
    opcode = 6'b100011;
    for (int i = 0; i < 10 && m_state != 3; i++) begin mem_ready = 1'b1; tick(); end
    check("reached_memrd", 32'(m_state), 32'd3);
    mem_ready = 1'b0;
    tick();
    #3 reset = 1'b1;
    #1;
    check("async_reset_state", 32'(state), 32'd0);
    check("async_reset_outs", 32'(dut_o), 32'd0);
    model_reset();
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    tick();
    check("post_reset_fetch", 32'({last_st, last_o.mem_read}), 32'd1);

    // random traffic: mostly-ready memory, then starved memory with timeouts
    for (int c = 0; c < 2500; c++) begin
      if (m_state == 0) opcode = pick_op();
      pct = (c < 1800) ? 70 : 12;
      mem_ready = ($urandom_range(0, 99) < pct);
      funct = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
